// File: rtl/bac_io_pkg.sv
// Shared types and width helpers for the BAC-02 I/O bus arbiter.
// The arbiter's optional burst mode is enabled with the BAC_IO_BURST_EN macro.
package bac_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam int NREQ_MAX = 4;

    // Owner index width; a single master still gets a 1-bit index.
    function automatic int owner_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Burst counter must reach MAX_BURST-1.
    function automatic int burst_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/bac_rr_picker.sv
// Combinational round-robin picker: chooses the first requester after rr_ptr,
// wrapping cyclically, so the master served last has the lowest priority.
module bac_rr_picker
    import bac_io_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int OWNER_W = 1
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] rr_ptr,
    output logic [OWNER_W-1:0] grant,
    output logic               any_req
);

    logic               found;
    logic [OWNER_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = OWNER_W'((int'(rr_ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bac_io_arbiter.sv
// BAC-02 peripheral bus arbiter: CPU has absolute priority, secondary masters share idle
// cycles round-robin. Define BAC_IO_BURST_EN to let a master hold its grant with m_lock.
module bac_io_arbiter
    import bac_io_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_out,
    input  logic              cpu_in,
    output logic [7:0]        cpu_din,
    input  logic [NREQ-1:0]   m_req,
    input  logic [NREQ-1:0]   m_we,
    input  logic [8*NREQ-1:0] m_addr,
    input  logic [8*NREQ-1:0] m_wdata,
    input  logic [NREQ-1:0]   m_lock,
    output logic [NREQ-1:0]   m_ack,
    output logic [7:0]        m_rdata,
    output logic [7:0]        io_addr,
    output logic [7:0]        io_wdata,
    output logic              io_wr,
    output logic              io_rd,
    input  logic [7:0]        io_rdata,
    output state_t            dbg_state
);

    localparam int OWNER_W = owner_w(NREQ);
    localparam int BURST_W = burst_w(MAX_BURST);

    // Handshake: a master raises m_req with m_we/m_addr/m_wdata and holds them stable
    // until its one-cycle m_ack; in the ack cycle it either drops m_req or presents a
    // new request. Dropping m_req before the access withdraws it silently (no ack).
    state_t             state, state_d;
    logic [OWNER_W-1:0] owner, owner_d;
    logic [OWNER_W-1:0] rr_ptr, rr_ptr_d;
    logic [OWNER_W-1:0] pick;
    logic               any_req;
    logic [NREQ-1:0]    ack_d;
    logic [7:0]         rdata_d;

    logic               cpu_busy;
    logic               sel_req;
    logic               sel_we;
    logic [7:0]         sel_addr;
    logic [7:0]         sel_wdata;

`ifdef BAC_IO_BURST_EN
    logic [BURST_W-1:0] burst_cnt, burst_cnt_d;
`else
    logic unused_lock;
    assign unused_lock = ^m_lock;
`endif

    assign cpu_busy  = cpu_in | cpu_out;
    assign sel_req   = m_req[owner];
    assign sel_we    = m_we[owner];
    assign sel_addr  = m_addr[int'(owner)*8 +: 8];
    assign sel_wdata = m_wdata[int'(owner)*8 +: 8];
    assign cpu_din   = io_rdata;
    assign dbg_state = state;

    bac_rr_picker #(
        .NREQ    (NREQ),
        .OWNER_W (OWNER_W)
    ) u_picker (
        .req     (m_req),
        .rr_ptr  (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    // Bus mux: the CPU cannot stall, so its strobes override any granted master.
    always_comb begin
        io_addr  = 8'h00;
        io_wdata = 8'h00;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        if (cpu_busy) begin
            io_addr  = cpu_addr;
            io_wdata = cpu_dout;
            io_wr    = cpu_out;
            io_rd    = cpu_in;
        end else if (state == ST_GRANT && sel_req) begin
            io_addr  = sel_addr;
            io_wdata = sel_wdata;
            io_wr    = sel_we;
            io_rd    = ~sel_we;
        end
    end

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        ack_d    = '0;
        rdata_d  = m_rdata;
`ifdef BAC_IO_BURST_EN
        burst_cnt_d = burst_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    owner_d = pick;
`ifdef BAC_IO_BURST_EN
                    burst_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Withdrawal wins over a pending access; a busy CPU just defers it.
                if (!sel_req) begin
                    state_d = ST_IDLE;
                end else if (!cpu_busy) begin
                    ack_d[owner] = 1'b1;
                    if (!sel_we) rdata_d = io_rdata;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                rr_ptr_d = owner;
                state_d  = ST_IDLE;
`ifdef BAC_IO_BURST_EN
                if (m_lock[owner] && burst_cnt < BURST_W'(MAX_BURST - 1)) begin
                    state_d     = ST_GRANT;
                    burst_cnt_d = burst_cnt + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= '0;
            rr_ptr  <= OWNER_W'(NREQ - 1);
            m_ack   <= '0;
            m_rdata <= 8'h00;
`ifdef BAC_IO_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            rr_ptr  <= rr_ptr_d;
            m_ack   <= ack_d;
            m_rdata <= rdata_d;
`ifdef BAC_IO_BURST_EN
            burst_cnt <= burst_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bac_io_arbiter.sv
// Self-checking bench for bac_io_arbiter: per-cycle vector table, round-robin and burst
// sequences, then randomized traffic against a memory-backed transaction model.
module tb_bac_io_arbiter;
    import bac_io_pkg::*;

    localparam int NREQ = 2;

    logic             clk;
    logic             reset;
    logic [7:0]       cpu_addr, cpu_dout, cpu_din;
    logic             cpu_out, cpu_in;
    logic [NREQ-1:0]  m_req, m_we, m_lock, m_ack;
    logic [8*NREQ-1:0] m_addr, m_wdata;
    logic [7:0]       m_rdata, io_addr, io_wdata, io_rdata;
    logic             io_wr, io_rd;
    state_t           dbg_state;

    bac_io_arbiter #(.NREQ(NREQ), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_out(cpu_out), .cpu_in(cpu_in),
        .cpu_din(cpu_din),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_lock(m_lock),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
        .io_rdata(io_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / peripheral model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       use_mem = 1'b0;
    logic [7:0] drv_rdata = 8'h00;
    logic [7:0] mem [256];

    assign io_rdata = use_mem ? mem[io_addr] : drv_rdata;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
        end else if (use_mem && io_wr) begin
            mem[io_addr] <= io_wdata;
        end
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] caddr, cdout;
        logic       cout, cin;
        logic [1:0] req, we;
        logic [7:0] a0, a1, w0, w1, rd;
        logic [7:0] e_addr, e_wdata;
        logic       e_wr, e_rd;
        logic [1:0] e_ack;
        logic [7:0] e_rdata;
        state_t     e_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic [7:0] caddr, input logic [7:0] cdout,
        input logic cout, input logic cin, input logic [1:0] req, input logic [1:0] we,
        input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] w0, input logic [7:0] w1,
        input logic [7:0] rd, input logic [7:0] ea, input logic [7:0] ew,
        input logic ewr, input logic erd, input logic [1:0] eack, input logic [7:0] erdata,
        input state_t est);
        vec_t v;
        v.rst = rst; v.caddr = caddr; v.cdout = cdout; v.cout = cout; v.cin = cin;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1; v.rd = rd;
        v.e_addr = ea; v.e_wdata = ew; v.e_wr = ewr; v.e_rd = erd; v.e_ack = eack;
        v.e_rdata = erdata; v.e_st = est;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset     = v.rst;
        cpu_addr  = v.caddr;
        cpu_dout  = v.cdout;
        cpu_out   = v.cout;
        cpu_in    = v.cin;
        m_req     = v.req;
        m_we      = v.we;
        m_addr    = {v.a1, v.a0};
        m_wdata   = {v.w1, v.w0};
        drv_rdata = v.rd;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; cpu_addr = 8'h00; cpu_dout = 8'h00; cpu_out = 1'b0; cpu_in = 1'b0;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_lock = '0; drv_rdata = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- randomized traffic with transaction model ----------------
    logic       pend  [NREQ];
    logic       p_we  [NREQ];
    logic [7:0] p_addr[NREQ];
    logic [7:0] p_wdata[NREQ];
    int         p_wait[NREQ];
    int         acks_seen = 0;

    task automatic rand_cycle(input bit allow_new);
        int r;
        logic matched;
        @(negedge clk);
        // CPU strobes always own the bus, whatever the arbiter is doing.
        if (cpu_out || cpu_in) begin
            check("cpu_bus", {io_addr, io_wdata, io_wr, io_rd}, {cpu_addr, cpu_dout, cpu_out, cpu_in});
        end else if (io_wr || io_rd) begin
            matched = 1'b0;
            for (int i = 0; i < NREQ; i++)
                if (pend[i] && io_addr == p_addr[i] && io_wr == p_we[i] && (!p_we[i] || io_wdata == p_wdata[i]))
                    matched = 1'b1;
            check("master_bus", matched, 1);
        end
        if (m_ack != '0) check("ack_onehot", $countones(m_ack), 1);
        for (int i = 0; i < NREQ; i++) begin
            if (m_ack[i]) begin
                check($sformatf("ack_pending%0d", i), pend[i], 1);
                if (pend[i]) begin
                    if (p_we[i]) check($sformatf("wr_data%0d", i), mem[p_addr[i]], p_wdata[i]);
                    else         check($sformatf("rd_data%0d", i), m_rdata, mem[p_addr[i]]);
                    acks_seen++;
                end
                pend[i] = 1'b0;
            end else if (pend[i]) begin
                p_wait[i]++;
                if (p_wait[i] > 300) begin
                    check($sformatf("ack_timeout%0d", i), p_wait[i], 0);
                    pend[i] = 1'b0;
                end
            end
        end
        r = $urandom_range(0, 9);
        cpu_out  = (r < 2);
        cpu_in   = (r >= 2 && r < 4);
        cpu_addr = 8'($urandom_range(0, 255));
        cpu_dout = 8'($urandom_range(0, 255));
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && allow_new && $urandom_range(0, 2) == 0) begin
                pend[i]    = 1'b1;
                p_we[i]    = 1'($urandom_range(0, 1));
                p_addr[i]  = 8'($urandom_range(0, 15));
                p_wdata[i] = 8'($urandom_range(0, 255));
                p_wait[i]  = 0;
            end
            m_req[i]            = pend[i];
            m_we[i]             = p_we[i];
            m_addr[i*8 +: 8]    = p_addr[i];
            m_wdata[i*8 +: 8]   = p_wdata[i];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];
        int gcyc[$];
        logic any_pend;

        idle_inputs();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 8'h00; p_wdata[i] = 8'h00; p_wait[i] = 0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_ack", m_ack, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_bus", {io_addr, io_wdata, io_wr, io_rd}, 0);

        // single read, latency T0 -> T1 access -> T2 ack
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b01,2'b00,8'h20,8'h00,8'h00,8'h00,8'h5A, 8'h00,8'h00,0,0,2'b00,8'h00,ST_IDLE));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b01,2'b00,8'h20,8'h00,8'h00,8'h00,8'h5A, 8'h20,8'h00,0,1,2'b00,8'h00,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h20,8'h00,8'h00,8'h00,8'h5A, 8'h00,8'h00,0,0,2'b01,8'h5A,ST_ACK));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        // CPU collides with master 1 write; master deferred one cycle
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b10,2'b10,8'h00,8'h10,8'h00,8'h33,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        vecs.push_back(mk(0,8'h10,8'hAA,1,0,2'b10,2'b10,8'h00,8'h10,8'h00,8'h33,8'h00, 8'h10,8'hAA,1,0,2'b00,8'h5A,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b10,2'b10,8'h00,8'h10,8'h00,8'h33,8'h00, 8'h10,8'h33,1,0,2'b00,8'h5A,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b10,8'h5A,ST_ACK));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        // master 0 withdraws while the CPU reads
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b01,2'b00,8'h40,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        vecs.push_back(mk(0,8'h77,8'h00,0,1,2'b01,2'b00,8'h40,8'h00,8'h00,8'h00,8'h99, 8'h77,8'h00,0,1,2'b00,8'h5A,ST_GRANT));
        vecs.push_back(mk(0,8'h77,8'h00,0,1,2'b00,2'b00,8'h40,8'h00,8'h00,8'h00,8'h99, 8'h77,8'h00,0,1,2'b00,8'h5A,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        // reset in GRANT with CPU busy, then master 0 wins
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b10,2'b10,8'h00,8'h50,8'h00,8'h55,8'h00, 8'h00,8'h00,0,0,2'b00,8'h5A,ST_IDLE));
        vecs.push_back(mk(1,8'h60,8'h66,1,0,2'b10,2'b10,8'h00,8'h50,8'h00,8'h55,8'h00, 8'h60,8'h66,1,0,2'b00,8'h5A,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b11,2'b10,8'h41,8'h50,8'h00,8'h55,8'hC3, 8'h00,8'h00,0,0,2'b00,8'h00,ST_IDLE));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b11,2'b10,8'h41,8'h50,8'h00,8'h55,8'hC3, 8'h41,8'h00,0,1,2'b00,8'h00,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b10,2'b10,8'h41,8'h50,8'h00,8'h55,8'hC3, 8'h00,8'h00,0,0,2'b01,8'hC3,ST_ACK));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b10,2'b10,8'h00,8'h50,8'h00,8'h55,8'h00, 8'h00,8'h00,0,0,2'b00,8'hC3,ST_IDLE));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b10,2'b10,8'h00,8'h50,8'h00,8'h55,8'h00, 8'h50,8'h55,1,0,2'b00,8'hC3,ST_GRANT));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b10,8'hC3,ST_ACK));
        vecs.push_back(mk(0,8'h00,8'h00,0,0,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,2'b00,8'hC3,ST_IDLE));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_bus", i), {io_addr, io_wdata, io_wr, io_rd},
                  {vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_wr, vecs[i].e_rd});
            check($sformatf("v%0d_ack", i), m_ack, vecs[i].e_ack);
            check($sformatf("v%0d_rdata", i), m_rdata, vecs[i].e_rdata);
            check($sformatf("v%0d_state", i), dbg_state, vecs[i].e_st);
            check($sformatf("v%0d_cpu_din", i), cpu_din, vecs[i].rd);
        end

        // round-robin: both masters request continuously
        @(negedge clk);
        idle_inputs();
        m_req = 2'b11;
        m_addr = {8'h02, 8'h01};
        for (int c = 0; c < 60 && got.size() < 6; c++) begin
            @(negedge clk);
            if (m_ack != '0) begin
                got.push_back(m_ack[1] ? 1 : 0);
                gcyc.push_back(cyc);
            end
        end
        check("rr_count", got.size(), 6);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("rr_order%0d", k), got[k], k % 2);
            if (k > 0) check($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
        end
        @(negedge clk);
        idle_inputs();

`ifdef BAC_IO_BURST_EN
        // burst: master 1 locks, gets MAX_BURST acks 2 cycles apart, then master 0
        do_reset();
        got.delete();
        gcyc.delete();
        m_lock = 2'b10;
        m_req  = 2'b10;
        @(negedge clk);
        m_req  = 2'b11;
        for (int c = 0; c < 60 && got.size() < 5; c++) begin
            @(negedge clk);
            if (m_ack != '0) begin
                got.push_back(m_ack[1] ? 1 : 0);
                gcyc.push_back(cyc);
            end
        end
        check("burst_count", got.size(), 5);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("burst_order%0d", k), got[k], (k < 4) ? 1 : 0);
            if (k > 0 && k < 4) check($sformatf("burst_gap%0d", k), gcyc[k] - gcyc[k-1], 2);
        end
        @(negedge clk);
        idle_inputs();
`endif

        // randomized traffic against the memory model
        use_mem = 1'b1;
        do_reset();
        for (int n = 0; n < 1500; n++) rand_cycle(1'b1);
        for (int n = 0; n < 400; n++) begin
            any_pend = 1'b0;
            for (int i = 0; i < NREQ; i++) any_pend |= pend[i];
            if (!any_pend) break;
            rand_cycle(1'b0);
        end
        any_pend = 1'b0;
        for (int i = 0; i < NREQ; i++) any_pend |= pend[i];
        check("drain", any_pend, 0);
        check("acks_progress", (acks_seen > 50) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
